dial_encoder: RTL and testbench
===============================

// Module: dial_encoder
// PURPOSE
//  Front end of the combination-safe datapath. Turns the raw quadrature contacts of the
//  rotary dial into a wrapping dial position. It sits directly upstream of the safe's
//  master FSM and feeds it cnten, up, dirch and eq. It takes clrCount and sel back from
//  the FSM and consumes the three-digit combination from the code store.
// PARAMETERS
//  CNT_W       6     width of dial position and of each code digit
//  DIAL_MAX    39    highest dial number; position range 0..DIAL_MAX
//  DEB_CYCLES  16    consecutive stable cycles before a contact change is accepted
//  IDLE_CYCLES 4096  cycles without a detent before the dial counts as at rest
// PORTS
//  clk        in   1        system clock, all state on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  enc_a      in   1        raw dial contact A, asynchronous, bouncy
//  enc_b      in   1        raw dial contact B, asynchronous, bouncy
//  clr_count  in   1        synchronous clear from FSM (clrCount)
//  sel        in   2        digit under test: 0,1,2; 3 = none
//  code       in   3*CNT_W  combination {d2,d1,d0}, d0 in LSBs
//  count      out  CNT_W    current dial position
//  cnten      out  1        1 = dial moved within last IDLE_CYCLES
//  up         out  1        direction of last detent, 1 = CW/increment
//  dirch      out  1        1-cycle pulse on a direction reversal
//  eq         out  1        registered compare of position with the selected digit
//  enc_err    out  1        1-cycle pulse on an illegal quadrature jump
// BEHAVIOUR
//  Reset (rst_n=0, async): count=0, cnten=0, up=1, dirch=0, eq=0, enc_err=0,
//   filtered AB=00, dir_valid=0, all sync, debounce and idle counters=0.
//  Input path: each contact has a 2-FF synchronizer, then a debounce counter. The
//   filtered bit takes the synced value only after DEB_CYCLES consecutive equal samples
//   that differ from the filtered bit. Any mismatch restarts that contact's counter.
//  Quadrature FSM on filtered {A,B}, states S00/S01/S11/S10.
//   CW order: 00->01->11->10->00. CCW is the reverse.
//   Legal single-bit moves update the state.
//   Two-bit jumps (00<->11, 01<->10) update the state and pulse enc_err. They produce no detent.
//  Detent event = entry to S00. From S10 = CW step (+1). From S01 = CCW step (-1).
//  Position arithmetic is modulo (DIAL_MAX+1):
//   +1 at DIAL_MAX -> 0; -1 at 0 -> DIAL_MAX. count is never > DIAL_MAX.
//  On each detent edge:
//   - count updates and up <= step direction.
//   - The idle counter reloads to IDLE_CYCLES-1 and cnten <= 1.
//   - If dir_valid and the step direction != up: dirch <= 1, and eq compares the
//     PRE-step count. This lets the FSM judge the number the user turned back at.
//   - dir_valid <= 1.
//  No detent: the idle counter decrements to 0. cnten <= 0 when it is 0.
//   dirch <= 0. eq <= (count == code[sel]).
//  sel=3 forces eq <= 0. eq has 1-cycle latency from a count or sel/code change.
//  clr_count=1 (sync): count=0, up=1, dir_valid=0, cnten=0, idle counter=0, dirch=0, eq=0.
//   It wins over a detent in the same cycle. Debounce and quadrature state are kept,
//   so no false step appears after the clear.
//  After a clear or reset, the first detent never produces dirch.
//  rst_n asserted mid-rotation discards partial debounce progress.
//   After release the dial resumes from the filtered AB=00 state.
// TESTING
//  1. Reset, then 3 clean CW cycles (each level held >DEB_CYCLES) -> count 0->1->2->3,
//     up=1, no dirch, no enc_err.
//  2. count=39, one CW detent -> count=0. Then one CCW detent -> dirch pulse,
//     eq checked against 0, count=39, up=0.
//  3. code d0=5, sel=0, turn CW to 5 then 1 CCW detent -> dirch=1 with eq=1 same cycle,
//     count=4 after.
//  4. A toggles 8 times with 3-cycle bounces before settling -> exactly one filtered
//     change, no extra count.
//  5. Filtered AB jumps 00->11 -> enc_err pulse, count unchanged.
//     clr_count coincident with a detent -> count=0, cnten=0.
//  6. Stop turning -> cnten falls exactly IDLE_CYCLES cycles after the last detent.
//     rst_n pulse mid-turn -> all outputs at reset values.

Source files
------------

// File: rtl/dial_encoder.sv
// Rotary dial front end: synchronises and debounces the quadrature contacts, decodes
// detents into a wrapping position, and compares that position with the selected code digit.
module dial_encoder #(
  parameter int CNT_W       = 6,
  parameter int DIAL_MAX    = 39,
  parameter int DEB_CYCLES  = 16,
  parameter int IDLE_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               clr_count,
  input  logic [1:0]         sel,
  input  logic [3*CNT_W-1:0] code,
  output logic [CNT_W-1:0]   count,
  output logic               cnten,
  output logic               up,
  output logic               dirch,
  output logic               eq,
  output logic               enc_err
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] POS_MAX = CNT_W'(DIAL_MAX);

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } quad_t;

  // Bit 1 carries contact A, bit 0 carries contact B.
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       filt_r;
  logic [DEB_W-1:0] deb_cnt_r [2];

  quad_t            state_r;
  quad_t            state_s;
  logic             step_cw_s;
  logic             step_ccw_s;
  logic             jump_s;

  logic [IDLE_W-1:0] idle_r;
  logic              dir_valid_r;
  logic [CNT_W-1:0]  digit_s;
  logic              sel_ok_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [CNT_W-1:0]  cnt_dec_s;
  logic              eq_s;
  logic              detent_s;
  logic              rev_s;

  // Synchronise both contacts and accept a new level after DEB_CYCLES differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
      filt_r  <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt_r[i] <= '0;
    end else begin
      sync1_r <= {enc_a, enc_b};
      sync2_r <= sync1_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] != filt_r[i]) begin
          if (deb_cnt_r[i] == DEB_W'(DEB_CYCLES - 1)) begin
            filt_r[i]    <= sync2_r[i];
            deb_cnt_r[i] <= '0;
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt_r[i] <= '0;
        end
      end
    end
  end

  // Quadrature state register; follows the filtered contacts one cycle behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S00;
      enc_err <= 1'b0;
    end else begin
      state_r <= state_s;
      enc_err <= jump_s;
    end
  end

  // Quadrature next state and step/jump decode; a detent is any legal entry into S00.
  always_comb begin
    state_s    = quad_t'(filt_r);
    step_cw_s  = 1'b0;
    step_ccw_s = 1'b0;
    jump_s     = 1'b0;
    case (state_r)
      S00: jump_s = (filt_r == 2'b11);
      S01: begin
        step_ccw_s = (filt_r == 2'b00);
        jump_s     = (filt_r == 2'b10);
      end
      S11: jump_s = (filt_r == 2'b00);
      S10: begin
        step_cw_s = (filt_r == 2'b00);
        jump_s    = (filt_r == 2'b01);
      end
      default: state_s = S00;
    endcase
  end

  // Digit select, modulo neighbours of the position, and reversal detection.
  always_comb begin
    digit_s  = '0;
    sel_ok_s = 1'b1;
    case (sel)
      2'd0:    digit_s = code[CNT_W-1:0];
      2'd1:    digit_s = code[2*CNT_W-1:CNT_W];
      2'd2:    digit_s = code[3*CNT_W-1:2*CNT_W];
      default: sel_ok_s = 1'b0;
    endcase
    cnt_inc_s = (count == POS_MAX) ? '0 : count + CNT_W'(1);
    cnt_dec_s = (count == '0) ? POS_MAX : count - CNT_W'(1);
    // eq always looks at the pre-step count, so on a reversal it reports the turn-back number.
    eq_s      = sel_ok_s && (count == digit_s);
    detent_s  = step_cw_s | step_ccw_s;
    rev_s     = dir_valid_r && (step_cw_s != up);
  end

  // Position, direction, activity and compare outputs; the FSM clear beats a detent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      up          <= 1'b1;
      dir_valid_r <= 1'b0;
      cnten       <= 1'b0;
      idle_r      <= '0;
      dirch       <= 1'b0;
      eq          <= 1'b0;
    end else if (clr_count) begin
      count       <= '0;
      up          <= 1'b1;
      dir_valid_r <= 1'b0;
      cnten       <= 1'b0;
      idle_r      <= '0;
      dirch       <= 1'b0;
      eq          <= 1'b0;
    end else if (detent_s) begin
      count       <= step_cw_s ? cnt_inc_s : cnt_dec_s;
      up          <= step_cw_s;
      dir_valid_r <= 1'b1;
      cnten       <= 1'b1;
      idle_r      <= IDLE_W'(IDLE_CYCLES - 1);
      dirch       <= rev_s;
      eq          <= eq_s;
    end else begin
      dirch <= 1'b0;
      eq    <= eq_s;
      if (idle_r == '0) begin
        cnten <= 1'b0;
      end else begin
        idle_r <= idle_r - IDLE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dial_encoder.sv
// Bench for dial_encoder: directed dial gestures plus a random walk, every cycle
// compared against a behavioural model of contacts, detents and modulo position.
module tb_dial_encoder;

  localparam int CNT_W    = 6;
  localparam int DIAL_MAX = 39;
  localparam int DEB      = 16;
  localparam int IDLE     = 4096;
  localparam int SETTLE   = 22;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enc_a;
  logic               enc_b;
  logic               clr_count;
  logic [1:0]         sel;
  logic [3*CNT_W-1:0] code;
  logic [CNT_W-1:0]   count;
  logic               cnten;
  logic               up;
  logic               dirch;
  logic               eq;
  logic               enc_err;

  int   total = 0;
  int   bad = 0;
  int   dirch_cnt = 0;
  int   err_cnt = 0;
  logic eq_at_dirch = 1'b0;

  // behavioural model state
  logic [1:0] m_d1, m_d2, m_filt, m_state;
  int         m_run [2];
  int         m_count, m_idle;
  logic       m_up, m_dv, m_cnten, m_dirch, m_eq, m_err;

  dial_encoder #(
    .CNT_W(CNT_W), .DIAL_MAX(DIAL_MAX), .DEB_CYCLES(DEB), .IDLE_CYCLES(IDLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clr_count(clr_count),
    .sel(sel), .code(code), .count(count), .cnten(cnten), .up(up), .dirch(dirch),
    .eq(eq), .enc_err(enc_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // position of a contact pair along the clockwise cycle 00,01,11,10
  function automatic int qidx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_d1 = 2'b00; m_d2 = 2'b00; m_filt = 2'b00; m_state = 2'b00;
    m_run[0] = 0; m_run[1] = 0;
    m_count = 0; m_idle = 0;
    m_up = 1'b1; m_dv = 1'b0; m_cnten = 1'b0; m_dirch = 1'b0; m_eq = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0] f_old, s_old, f_new;
    int         delta, digit;
    logic       detent, dir, eq_new;
    f_old = m_filt;
    s_old = m_state;
    f_new = m_filt;
    for (int i = 0; i < 2; i++) begin
      if (m_d2[i] !== m_filt[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          f_new[i] = m_d2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = {enc_a, enc_b};
    delta   = (qidx(f_old) - qidx(s_old) + 4) % 4;
    m_err   = (delta == 2);
    detent  = (f_old == 2'b00) && (delta == 1 || delta == 3);
    dir     = (delta == 1);
    m_state = f_old;
    m_filt  = f_new;
    digit  = int'((code >> (CNT_W * int'(sel))) & 18'h0003F);
    eq_new = (sel != 2'd3) && (m_count == digit);
    if (clr_count) begin
      m_count = 0; m_up = 1'b1; m_dv = 1'b0; m_cnten = 1'b0; m_idle = 0;
      m_dirch = 1'b0; m_eq = 1'b0;
    end else if (detent) begin
      m_dirch = m_dv && (dir != m_up);
      m_eq    = eq_new;
      m_count = dir ? (m_count + 1) % (DIAL_MAX + 1) : (m_count + DIAL_MAX) % (DIAL_MAX + 1);
      m_up    = dir;
      m_dv    = 1'b1;
      m_idle  = IDLE - 1;
      m_cnten = 1'b1;
    end else begin
      m_dirch = 1'b0;
      m_eq    = eq_new;
      if (m_idle == 0) m_cnten = 1'b0;
      else m_idle--;
    end
  endtask

  function automatic logic detent_pending();
    return (m_filt == 2'b00) && (m_state == 2'b10 || m_state == 2'b01);
  endfunction

  task automatic check_outputs();
    chk("count", 32'(count), 32'(m_count));
    chk("cnten", 32'(cnten), 32'(m_cnten));
    chk("up", 32'(up), 32'(m_up));
    chk("dirch", 32'(dirch), 32'(m_dirch));
    chk("eq", 32'(eq), 32'(m_eq));
    chk("enc_err", 32'(enc_err), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_outputs();
    if (dirch === 1'b1) begin
      dirch_cnt++;
      eq_at_dirch = eq;
    end
    if (enc_err === 1'b1) err_cnt++;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic set_ab(input logic a, input logic b);
    enc_a = a;
    enc_b = b;
    hold(SETTLE);
  endtask

  task automatic cw();
    set_ab(1'b0, 1'b1); set_ab(1'b1, 1'b1); set_ab(1'b1, 1'b0); set_ab(1'b0, 1'b0);
  endtask

  task automatic ccw();
    set_ab(1'b1, 1'b0); set_ab(1'b1, 1'b1); set_ab(1'b0, 1'b1); set_ab(1'b0, 1'b0);
  endtask

  task automatic run_to_detent();
    int n = 0;
    while (!detent_pending() && n < 40) begin
      tick();
      n++;
    end
    chk("detent_reached", 32'(n < 40), 32'd1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_cnten"}, 32'(cnten), 32'd0);
    chk({tag, "_up"}, 32'(up), 32'd1);
    chk({tag, "_dirch"}, 32'(dirch), 32'd0);
    chk({tag, "_eq"}, 32'(eq), 32'd0);
    chk({tag, "_enc_err"}, 32'(enc_err), 32'd0);
  endtask

  initial begin
    int base, n, pos;
    rst_n = 1'b0; enc_a = 1'b0; enc_b = 1'b0; clr_count = 1'b0;
    sel = 2'd3; code = '0;
    model_reset();
    hold(3);
    chk_reset_values("reset");
    rst_n = 1'b1;

    // 1: three clean clockwise detents
    for (int k = 1; k <= 3; k++) begin
      cw();
      chk("t1_count", 32'(count), 32'(k));
    end
    chk("t1_up", 32'(up), 32'd1);
    chk("t1_dirch_none", 32'(dirch_cnt), 32'd0);
    chk("t1_err_none", 32'(err_cnt), 32'd0);

    // 2: wrap 39 -> 0 clockwise, then reverse back to 39
    code = {6'($urandom_range(0, 39)), 6'($urandom_range(0, 39)), 6'd0};
    sel = 2'd0;
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    chk("t2_clear", 32'(count), 32'd0);
    repeat (39) cw();
    chk("t2_at_max", 32'(count), 32'd39);
    cw();
    chk("t2_wrap_up", 32'(count), 32'd0);
    chk("t2_no_dirch", 32'(dirch_cnt), 32'd0);
    ccw();
    chk("t2_dirch", 32'(dirch_cnt), 32'd1);
    chk("t2_eq_pre", 32'(eq_at_dirch), 32'd1);
    chk("t2_wrap_down", 32'(count), 32'd39);
    chk("t2_up", 32'(up), 32'd0);

    // 3: turn to digit 5 then reverse
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    code = {6'($urandom_range(0, 39)), 6'($urandom_range(0, 39)), 6'd5};
    sel = 2'd0;
    repeat (5) cw();
    chk("t3_at5", 32'(count), 32'd5);
    base = dirch_cnt;
    ccw();
    chk("t3_dirch", 32'(dirch_cnt), 32'(base + 1));
    chk("t3_eq", 32'(eq_at_dirch), 32'd1);
    chk("t3_count", 32'(count), 32'd4);

    // 4: bouncy contact A, short random bounce widths
    for (int i = 0; i < 8; i++) begin
      enc_a = ~enc_a;
      hold($urandom_range(2, 4));
    end
    enc_a = 1'b1;
    hold(SETTLE);
    chk("t4_no_count", 32'(count), 32'd4);
    chk("t4_no_err", 32'(err_cnt), 32'd0);
    enc_a = 1'b0;
    hold(SETTLE);
    chk("t4_single_step", 32'(count), 32'd5);

    // 5: illegal jump, then clear coincident with a detent
    set_ab(1'b1, 1'b1);
    chk("t5_err", 32'(err_cnt), 32'd1);
    chk("t5_count_kept", 32'(count), 32'd5);
    set_ab(1'b1, 1'b0);
    set_ab(1'b0, 1'b0);
    chk("t5_after_jump", 32'(count), 32'd6);
    set_ab(1'b0, 1'b1); set_ab(1'b1, 1'b1); set_ab(1'b1, 1'b0);
    enc_a = 1'b0;
    run_to_detent();
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    chk("t5_clr_count", 32'(count), 32'd0);
    chk("t5_clr_cnten", 32'(cnten), 32'd0);
    hold(SETTLE);
    chk("t5_no_false_step", 32'(count), 32'd0);

    // 6: idle timeout, then reset in the middle of a turn
    set_ab(1'b0, 1'b1); set_ab(1'b1, 1'b1); set_ab(1'b1, 1'b0);
    enc_a = 1'b0;
    run_to_detent();
    tick();
    chk("t6_step", 32'(count), 32'd1);
    n = 0;
    while (cnten === 1'b1 && n < IDLE + 100) begin
      tick();
      n++;
    end
    chk("t6_idle_fall", 32'(n), 32'(IDLE));
    enc_b = 1'b1;
    hold(8);
    rst_n = 1'b0;
    #1;
    chk_reset_values("t6_rst");
    hold(3);
    rst_n = 1'b1;
    hold(SETTLE);
    chk("t6_resume", 32'(count), 32'd0);
    base = dirch_cnt;
    set_ab(1'b0, 1'b0);
    chk("t6_ccw_from_reset", 32'(count), 32'd39);
    chk("t6_no_dirch", 32'(dirch_cnt), 32'(base));

    // random walk with changing digit selection
    pos = 39;
    repeat (30) begin
      if ($urandom_range(0, 3) == 0) begin
        sel  = 2'($urandom_range(0, 3));
        code = {6'($urandom_range(0, 39)), 6'($urandom_range(0, 39)), 6'($urandom_range(0, 39))};
      end
      if ($urandom_range(0, 1) == 1) begin
        cw();
        pos = (pos + 1) % (DIAL_MAX + 1);
      end else begin
        ccw();
        pos = (pos + DIAL_MAX) % (DIAL_MAX + 1);
      end
      chk("rand_pos", 32'(count), 32'(pos));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
